ysyx_220053_mem_arbiter: RTL and testbench
==========================================

// Module: ysyx_220053_mem_arbiter
// PURPOSE
//  Shares one memory port between the IFU fetch path (port I) and the EXU load/store path (port D).
//  One transaction in flight at a time; fixed-priority grant, optional round-robin.
//  Sits between the fetch/LSU request logic and the memory/bus interface.
//  Per-transaction watchdog returns an error response if memory never answers.
// PARAMETERS
//  AW       64   address width
//  DW       64   data width; wmask width = DW/8
//  TIMEOUT  255  max cycles in WAIT before error response; 0 = watchdog disabled
// PORTS
//  clk             in   1      clock, all state on rising edge
//  rst             in   1      asynchronous, active-low reset
//  i_req_valid     in   1      IFU read request
//  i_req_ready     out  1      IFU request accepted this cycle
//  i_addr          in   AW     IFU address
//  i_resp_valid    out  1      IFU response, 1-cycle pulse
//  i_rdata         out  DW     IFU read data
//  i_err           out  1      IFU response is a timeout error
//  d_req_valid     in   1      LSU request
//  d_req_ready     out  1      LSU request accepted this cycle
//  d_addr          in   AW     LSU address
//  d_wen           in   1      1 = write, 0 = read
//  d_wdata         in   DW     LSU write data
//  d_wmask         in   DW/8   LSU byte write mask
//  d_resp_valid    out  1      LSU response, 1-cycle pulse (reads and writes)
//  d_rdata         out  DW     LSU read data (0 for writes)
//  d_err           out  1      LSU response is a timeout error
//  mem_req_valid   out  1      downstream request
//  mem_req_ready   in   1      downstream accepts request
//  mem_addr/mem_wen/mem_wdata/mem_wmask  out  AW/1/DW/DW/8  registered payload
//  mem_resp_valid  in   1      downstream response
//  mem_rdata       in   DW     downstream read data
// BEHAVIOUR
//  Reset (rst=0, async): state IDLE, all outputs 0, payload regs 0, watchdog 0, RR pointer favours D.
//  FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE.
//  IDLE: if any req_valid, grant one; x_req_ready=1 combinationally for the winner only (never both);
//   payload latched (I: wen=0, wmask=0, wdata=0); -> REQ. No request: stay, all readys 0.
//  REQ: mem_req_valid=1, payload stable; on mem_req_ready -> WAIT, watchdog cleared.
//  WAIT: mem_resp_valid sampled only here; on it, latch mem_rdata (0 if write) -> RESP.
//   Watchdog +1 per WAIT cycle; when it equals TIMEOUT (TIMEOUT!=0) -> RESP with err=1, rdata=0.
//   mem_resp_valid and timeout in same cycle: response wins, err=0.
//  RESP: owner's x_resp_valid=1 for exactly one cycle with registered rdata/err; -> IDLE.
//  Minimum latency: grant cycle N, mem_req_valid N+1, resp in WAIT at N+2, x_resp_valid N+3.
//  mem_resp_valid outside WAIT (late/stray) ignored. Requests in REQ/WAIT/RESP: ready=0, requester holds.
//  Non-owner resp_valid/rdata/err stay 0. Reset mid-transaction aborts it; no response ever issued.
// CONFIGURATION
//  YSYX_220053_ARB_RR_EN undefined: fixed priority, D always beats I on simultaneous request.
//  YSYX_220053_ARB_RR_EN defined: round-robin; 1-bit pointer, loser of last grant has priority;
//   pointer updates only on grant; single requester always granted regardless of pointer.
// TESTING
//  I read alone, mem_req_ready=1, resp after 1 cycle, rdata=0x00000013 -> i_resp_valid at N+3, i_rdata=0x13, i_err=0.
//  D write addr=0x80000100 wdata=0xDEADBEEF wmask=0x0F -> mem payload matches, d_resp_valid pulse, d_rdata=0.
//  I and D both valid in IDLE -> fixed: D then I; RR: D,I,D,I over 4 back-to-back rounds.
//  mem_req_ready held 0 for 5 cycles -> mem payload stable, mem_req_valid held, no readys asserted.
//  TIMEOUT=4, no mem_resp_valid -> x_resp_valid with err=1, rdata=0; late mem_resp_valid in IDLE ignored.
//  rst=0 asserted in WAIT -> all outputs 0 same cycle, no response after release, next request served normally.

Source files
------------

// File: rtl/ysyx_220053_mem_arbiter.sv
// Two-port (IFU fetch / LSU) arbiter onto a single memory port, one transaction in flight, with a WAIT watchdog.
// Define YSYX_220053_ARB_RR_EN for round-robin grant; default is fixed priority with D beating I.
module ysyx_220053_mem_arbiter #(
  parameter int AW      = 64,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req_valid,
  output logic            i_req_ready,
  input  logic [AW-1:0]   i_addr,
  output logic            i_resp_valid,
  output logic [DW-1:0]   i_rdata,
  output logic            i_err,
  input  logic            d_req_valid,
  output logic            d_req_ready,
  input  logic [AW-1:0]   d_addr,
  input  logic            d_wen,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_wmask,
  output logic            d_resp_valid,
  output logic [DW-1:0]   d_rdata,
  output logic            d_err,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [AW-1:0]   mem_addr,
  output logic            mem_wen,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_wmask,
  input  logic            mem_resp_valid,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] TO_CNT = WDW'(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;

  state_e            state_q;
  logic              owner_q;
  logic              mem_req_valid_q;
  logic [AW-1:0]     mem_addr_q;
  logic              mem_wen_q;
  logic [DW-1:0]     mem_wdata_q;
  logic [DW/8-1:0]   mem_wmask_q;
  logic [WDW-1:0]    wdog_q;
  logic              i_resp_valid_q, d_resp_valid_q;
  logic [DW-1:0]     i_rdata_q, d_rdata_q;
  logic              i_err_q, d_err_q;

  logic              idle, d_wins, i_grant, d_grant;
  logic [WDW-1:0]    wdog_inc;
  logic              timed_out, resp_err;
  logic [DW-1:0]     resp_rdata;

  // Readys are gated by rst so every output is quiet while reset is held.
  assign idle = rst && (state_q == S_IDLE);

`ifdef YSYX_220053_ARB_RR_EN
  logic rr_q;  // 1 = D has priority on a tie
  assign d_wins = d_req_valid && (!i_req_valid || rr_q);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_q <= 1'b1;
    end else if (i_grant || d_grant) begin
      rr_q <= i_grant;
    end
  end
`else
  assign d_wins = d_req_valid;
`endif

  assign d_grant     = idle && d_wins;
  assign i_grant     = idle && i_req_valid && !d_wins;
  assign d_req_ready = d_grant;
  assign i_req_ready = i_grant;

  assign wdog_inc   = wdog_q + 1'b1;
  assign timed_out  = (TIMEOUT != 0) && (wdog_inc == TO_CNT);
  // A real response beats a timeout landing in the same cycle.
  assign resp_err   = !mem_resp_valid;
  assign resp_rdata = (mem_resp_valid && !mem_wen_q) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      owner_q         <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_addr_q      <= '0;
      mem_wen_q       <= 1'b0;
      mem_wdata_q     <= '0;
      mem_wmask_q     <= '0;
      wdog_q          <= '0;
      i_resp_valid_q  <= 1'b0;
      i_rdata_q       <= '0;
      i_err_q         <= 1'b0;
      d_resp_valid_q  <= 1'b0;
      d_rdata_q       <= '0;
      d_err_q         <= 1'b0;
    end else begin
      i_resp_valid_q <= 1'b0;
      i_rdata_q      <= '0;
      i_err_q        <= 1'b0;
      d_resp_valid_q <= 1'b0;
      d_rdata_q      <= '0;
      d_err_q        <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (d_grant) begin
            owner_q         <= 1'b1;
            mem_addr_q      <= d_addr;
            mem_wen_q       <= d_wen;
            mem_wdata_q     <= d_wdata;
            mem_wmask_q     <= d_wmask;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
          end else if (i_grant) begin
            owner_q         <= 1'b0;
            mem_addr_q      <= i_addr;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '0;
            mem_req_valid_q <= 1'b1;
            state_q         <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            wdog_q          <= '0;
            state_q         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_resp_valid || timed_out) begin
            state_q <= S_RESP;
            if (owner_q) begin
              d_resp_valid_q <= 1'b1;
              d_rdata_q      <= resp_rdata;
              d_err_q        <= resp_err;
            end else begin
              i_resp_valid_q <= 1'b1;
              i_rdata_q      <= resp_rdata;
              i_err_q        <= resp_err;
            end
          end else begin
            wdog_q <= wdog_inc;
          end
        end
        S_RESP: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_req_valid = mem_req_valid_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wen       = mem_wen_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;
  assign i_resp_valid  = i_resp_valid_q;
  assign i_rdata       = i_rdata_q;
  assign i_err         = i_err_q;
  assign d_resp_valid  = d_resp_valid_q;
  assign d_rdata       = d_rdata_q;
  assign d_err         = d_err_q;

endmodule

// File: tb/tb_ysyx_220053_mem_arbiter.sv
// Scoreboard bench for ysyx_220053_mem_arbiter: port drivers, a memory responder, and monitors for grants, payloads and responses.
module tb_ysyx_220053_mem_arbiter;

  logic        clk, rst;
  logic        i_req_valid, i_req_ready, i_resp_valid, i_err;
  logic [63:0] i_addr, i_rdata;
  logic        d_req_valid, d_req_ready, d_wen, d_resp_valid, d_err;
  logic [63:0] d_addr, d_wdata, d_rdata;
  logic [7:0]  d_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;
  logic [7:0]  mem_wmask;

  ysyx_220053_mem_arbiter #(.AW(64), .DW(64), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
    .i_resp_valid(i_resp_valid), .i_rdata(i_rdata), .i_err(i_err),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
    .d_wen(d_wen), .d_wdata(d_wdata), .d_wmask(d_wmask),
    .d_resp_valid(d_resp_valid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wmask;
  } req_t;
  typedef struct {
    logic        port;   // 1 = D
    logic [63:0] rdata;
    logic        err;
  } resp_t;

  req_t  iq[$], dq[$], em[$];
  logic  eg[$];
  resp_t er[$];

  int checks = 0, passes = 0;
  int cyc = 0, last_grant_cyc = 0, last_resp_cyc = 0;
  bit i_hs = 0, d_hs = 0;
  bit ready_en = 1, mem_silent = 0, stray = 0;
  int resp_delay = 1;

  task automatic check(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    return (a == 64'h8000_0000) ? 64'h13 : {a[31:0] ^ 32'h5A5A_5A5A, a[31:0]};
  endfunction

  task automatic push_i(input logic [63:0] a);
    iq.push_back('{a, 1'b0, 64'd0, 8'd0});
  endtask

  task automatic push_d(input logic [63:0] a, input logic w, input logic [63:0] wd, input logic [7:0] wm);
    dq.push_back('{a, w, wd, wm});
  endtask

  task automatic expect_tx(input logic port, input logic [63:0] a, input logic w, input logic [63:0] wd,
                           input logic [7:0] wm, input logic [63:0] rd, input logic e);
    eg.push_back(port);
    em.push_back('{a, w, wd, wm});
    er.push_back('{port, rd, e});
  endtask

  task automatic check_zero(input string nm);
    logic any;
    any = i_req_ready | d_req_ready | i_resp_valid | d_resp_valid | i_err | d_err | mem_req_valid |
          mem_wen | (|mem_addr) | (|mem_wdata) | (|mem_wmask) | (|i_rdata) | (|d_rdata);
    check(!any, nm, 64'(any), 64'd0);
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((iq.size() + dq.size() + eg.size() + em.size() + er.size()) != 0 && n < 200) begin
      @(negedge clk); #3;
      n++;
    end
    check(n < 200, {nm, "_done"}, 64'(er.size()), 64'd0);
    if (n >= 200) begin
      iq.delete(); dq.delete(); eg.delete(); em.delete(); er.delete();
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(negedge clk); #3; end
  endtask

  initial begin clk = 0; forever #5 clk = ~clk; end
  initial forever begin @(posedge clk); cyc++; end

  // Port drivers: a request stays valid until handshaken, then the next queued one is presented.
  initial begin
    req_t tmp;
    i_req_valid = 0; i_addr = '0;
    d_req_valid = 0; d_addr = '0; d_wen = 0; d_wdata = '0; d_wmask = '0;
    forever begin
      @(negedge clk);
      if (i_hs && iq.size() > 0) tmp = iq.pop_front();
      if (d_hs && dq.size() > 0) tmp = dq.pop_front();
      if (iq.size() > 0) begin
        i_req_valid = 1; i_addr = iq[0].addr;
      end else begin
        i_req_valid = 0; i_addr = 64'hBAD0_BAD0_BAD0_BAD0;
      end
      if (dq.size() > 0) begin
        d_req_valid = 1; d_addr = dq[0].addr; d_wen = dq[0].wen;
        d_wdata = dq[0].wdata; d_wmask = dq[0].wmask;
      end else begin
        d_req_valid = 0; d_addr = '1; d_wen = 1; d_wdata = 64'hBADB_ADBA_DBAD_BADB; d_wmask = '1;
      end
      #1;
      i_hs = i_req_valid && i_req_ready;
      d_hs = d_req_valid && d_req_ready;
    end
  end

  // Memory responder: answers resp_delay cycles after the request handshake.
  initial begin
    int cnt = 0;
    bit pend = 0;
    mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 0; mem_rdata = '0;
      mem_req_ready = ready_en;
      if (!rst) begin
        pend = 0;
      end else begin
        if (stray) begin
          mem_resp_valid = 1; mem_rdata = '1; stray = 0;
        end
        if (pend) begin
          cnt--;
          if (cnt == 0) begin
            pend = 0; mem_resp_valid = 1; mem_rdata = mem_model(mem_addr);
          end
        end
        if (mem_req_valid && mem_req_ready && !mem_silent) begin
          pend = 1; cnt = resp_delay;
        end
      end
    end
  end

  // Grant monitor
  initial forever begin
    logic e;
    @(negedge clk); #1;
    if (i_req_ready && d_req_ready) check(0, "both_ready", 64'd3, 64'd1);
    else if (i_req_ready || d_req_ready) begin
      if (eg.size() == 0) check(0, "unexpected_grant", 64'(d_req_ready), 64'd0);
      else begin
        e = eg.pop_front();
        check(d_req_ready == e, "grant_port", 64'(d_req_ready), 64'(e));
        last_grant_cyc = cyc;
      end
    end
  end

  // Memory payload monitor
  initial forever begin
    req_t e;
    @(negedge clk); #1;
    if (mem_req_valid && mem_req_ready) begin
      if (em.size() == 0) check(0, "unexpected_mem_req", mem_addr, 64'd0);
      else begin
        e = em.pop_front();
        check(mem_addr == e.addr, "mem_addr", mem_addr, e.addr);
        check(mem_wdata == e.wdata, "mem_wdata", mem_wdata, e.wdata);
        check({mem_wen, mem_wmask} == {e.wen, e.wmask}, "mem_wen_wmask",
              64'({mem_wen, mem_wmask}), 64'({e.wen, e.wmask}));
      end
    end
  end

  // Response monitor
  initial forever begin
    resp_t e;
    @(negedge clk); #1;
    if (i_resp_valid && d_resp_valid) check(0, "both_resp", 64'd3, 64'd1);
    else if (i_resp_valid || d_resp_valid) begin
      if (er.size() == 0) check(0, "unexpected_resp", 64'(d_resp_valid), 64'd0);
      else begin
        e = er.pop_front();
        last_resp_cyc = cyc;
        check(d_resp_valid == e.port, "resp_port", 64'(d_resp_valid), 64'(e.port));
        if (d_resp_valid) begin
          check(d_rdata == e.rdata, "d_rdata", d_rdata, e.rdata);
          check(d_err == e.err, "d_err", 64'(d_err), 64'(e.err));
          check(i_rdata == 0 && !i_err, "i_nonowner_quiet", i_rdata, 64'd0);
        end else begin
          check(i_rdata == e.rdata, "i_rdata", i_rdata, e.rdata);
          check(i_err == e.err, "i_err", 64'(i_err), 64'(e.err));
          check(d_rdata == 0 && !d_err, "d_nonowner_quiet", d_rdata, 64'd0);
        end
      end
    end else begin
      check((i_rdata | d_rdata) == 0 && !i_err && !d_err, "resp_quiet", i_rdata | d_rdata, 64'd0);
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1;
    #1 rst = 0;
    cycles(2);
    check_zero("reset_state");
    rst = 1;

    // I read alone, minimum latency
    push_i(64'h8000_0000);
    expect_tx(1'b0, 64'h8000_0000, 1'b0, 64'd0, 8'd0, 64'h13, 1'b0);
    drain("i_read");
    check(last_resp_cyc - last_grant_cyc == 3, "i_latency", 64'(last_resp_cyc - last_grant_cyc), 64'd3);

    // D write
    push_d(64'h8000_0100, 1'b1, 64'hDEAD_BEEF, 8'h0F);
    expect_tx(1'b1, 64'h8000_0100, 1'b1, 64'hDEAD_BEEF, 8'h0F, 64'd0, 1'b0);
    drain("d_write");

    // Downstream stall with a second requester waiting
    ready_en = 0;
    push_d(64'h8000_0208, 1'b0, 64'd0, 8'd0);
    expect_tx(1'b1, 64'h8000_0208, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_0208), 1'b0);
    n = 0;
    while (eg.size() != 0 && n < 20) begin cycles(1); n++; end
    check(n < 20, "stall_grant", 64'(eg.size()), 64'd0);
    push_i(64'h8000_0010);
    expect_tx(1'b0, 64'h8000_0010, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_0010), 1'b0);
    for (int k = 0; k < 5; k++) begin
      cycles(1);
      check({mem_req_valid, i_req_ready, d_req_ready} == 3'b100, "stall_valid_readys",
            64'({mem_req_valid, i_req_ready, d_req_ready}), 64'd4);
      check(mem_addr == 64'h8000_0208 && !mem_wen, "stall_payload", mem_addr, 64'h8000_0208);
    end
    ready_en = 1;
    drain("stall");

    // Simultaneous single requests: D first either way
    push_d(64'h8000_0300, 1'b0, 64'd0, 8'd0);
    push_i(64'h8000_0400);
    expect_tx(1'b1, 64'h8000_0300, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_0300), 1'b0);
    expect_tx(1'b0, 64'h8000_0400, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_0400), 1'b0);
    drain("prio_once");

    // Back-to-back contention over four rounds
    push_d(64'h8000_1000, 1'b0, 64'd0, 8'd0);
    push_d(64'h8000_1008, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    push_i(64'h8000_2000);
    push_i(64'h8000_2004);
`ifdef YSYX_220053_ARB_RR_EN
    expect_tx(1'b1, 64'h8000_1000, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_1000), 1'b0);
    expect_tx(1'b0, 64'h8000_2000, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_2000), 1'b0);
    expect_tx(1'b1, 64'h8000_1008, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 64'd0, 1'b0);
    expect_tx(1'b0, 64'h8000_2004, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_2004), 1'b0);
`else
    expect_tx(1'b1, 64'h8000_1000, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_1000), 1'b0);
    expect_tx(1'b1, 64'h8000_1008, 1'b1, 64'h1234_5678_9ABC_DEF0, 8'hFF, 64'd0, 1'b0);
    expect_tx(1'b0, 64'h8000_2000, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_2000), 1'b0);
    expect_tx(1'b0, 64'h8000_2004, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_2004), 1'b0);
`endif
    drain("contention");

    // Watchdog: no response at all, then a stray response in IDLE
    mem_silent = 1;
    push_i(64'h8000_0500);
    expect_tx(1'b0, 64'h8000_0500, 1'b0, 64'd0, 8'd0, 64'd0, 1'b1);
    drain("timeout");
    check(last_resp_cyc - last_grant_cyc == 6, "timeout_latency", 64'(last_resp_cyc - last_grant_cyc), 64'd6);
    mem_silent = 0;
    stray = 1;
    cycles(4);

    // Response on the last watchdog cycle wins; one cycle later it is too late
    resp_delay = 4;
    push_d(64'h8000_0600, 1'b0, 64'd0, 8'd0);
    expect_tx(1'b1, 64'h8000_0600, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_0600), 1'b0);
    drain("resp_vs_timeout");
    resp_delay = 5;
    push_d(64'h8000_0700, 1'b0, 64'd0, 8'd0);
    expect_tx(1'b1, 64'h8000_0700, 1'b0, 64'd0, 8'd0, 64'd0, 1'b1);
    drain("late_resp");
    cycles(2);

    // Reset during WAIT aborts silently
    resp_delay = 20;
    push_i(64'h8000_0800);
    eg.push_back(1'b0);
    em.push_back('{64'h8000_0800, 1'b0, 64'd0, 8'd0});
    n = 0;
    while (em.size() != 0 && n < 20) begin cycles(1); n++; end
    check(n < 20, "rst_wait_entry", 64'(em.size()), 64'd0);
    cycles(2);
    rst = 0;
    #1;
    check_zero("reset_in_wait");
    cycles(1);
    rst = 1;
    cycles(25);
    resp_delay = 1;
    push_i(64'h8000_0900);
    expect_tx(1'b0, 64'h8000_0900, 1'b0, 64'd0, 8'd0, mem_model(64'h8000_0900), 1'b0);
    drain("after_reset");
    cycles(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
